// File: rtl/mult_share_ctrl_32b.sv
// Round-robin controller sharing one unsigned 32x32 array multiplier between two
// requesters; operands are held for SETTLE_CYCLES so the array runs as a multicycle path.

module array_multiplier_32b (
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] P
);

  logic [63:0] row [0:32];

  assign row[0] = '0;

  // One adder row per multiplier bit: row[i+1] accumulates A shifted by i when B[i] is set.
  for (genvar i = 0; i < 32; i++) begin : g_row
    logic [63:0] pp;
    assign pp         = B[i] ? ({32'd0, A} << i) : 64'd0;
    assign row[i + 1] = row[i] + pp;
  end

  assign P = row[32];

endmodule

module mult_share_ctrl_32b #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_A,
  input  logic [31:0] req0_B,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_A,
  input  logic [31:0] req1_B,
  output logic        req1_ready,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_id,
  output logic [63:0] resultado,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ptr_q;
  logic        id_q;
  logic [31:0] a_q, b_q;
  logic [63:0] prod;
  logic [63:0] res_q;
  logic        res_id_q;
  logic        any_req;
  logic        win;
  logic        grant;
  logic        capture;

  array_multiplier_32b u_mult (
    .A (a_q),
    .B (b_q),
    .P (prod)
  );

  always_comb begin
    any_req = req0_valid | req1_valid;
    // A lone requester wins outright; on contention the pointer decides.
    win     = (req0_valid & req1_valid) ? ptr_q : req1_valid;
    grant   = 1'b0;
    capture = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_req && !reset) begin
          grant   = 1'b1;
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        ptr_q <= ~win;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      res_q    <= '0;
      res_id_q <= 1'b0;
    end else begin
      if (grant) begin
        a_q  <= win ? req1_A : req0_A;
        b_q  <= win ? req1_B : req0_B;
        id_q <= win;
      end
      // res_id is captured alongside the product so it stays paired with resultado.
      if (capture) begin
        res_q    <= prod;
        res_id_q <= id_q;
      end
    end
  end

  assign req0_ready = grant & ~win;
  assign req1_ready = grant & win;
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign res_id     = res_id_q;
  assign resultado  = res_q;

endmodule

// File: tb/tb_mult_share_ctrl_32b.sv
// Self-checking bench for mult_share_ctrl_32b: transaction-level model compared every
// cycle, directed scenarios, literal result table, and settle-cycle sweep instances.

module tb_mult_share_ctrl_32b;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        r0v = 1'b0, r1v = 1'b0;
  logic [31:0] r0a = '0, r0b = '0, r1a = '0, r1b = '0;
  logic        r0r, r1r, resv, resid, busy;
  logic        resr = 1'b1;
  logic [63:0] res;

  always #5 clk = ~clk;

  mult_share_ctrl_32b #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .reset(rst),
    .req0_valid(r0v), .req0_A(r0a), .req0_B(r0b), .req0_ready(r0r),
    .req1_valid(r1v), .req1_A(r1a), .req1_B(r1b), .req1_ready(r1r),
    .res_valid(resv), .res_ready(resr), .res_id(resid), .resultado(res), .busy(busy)
  );

  // Sweep instances: SETTLE_CYCLES = 1 (driven on req0) and 15 (driven on req1).
  logic        a_v = 1'b0, a_r0, a_r1, a_rv, a_id, a_busy;
  logic [31:0] a_a = '0, a_b = '0;
  logic [63:0] a_res;
  logic        b_v = 1'b0, b_r0, b_r1, b_rv, b_id, b_busy;
  logic [31:0] b_a = '0, b_b = '0;
  logic [63:0] b_res;
  logic        one = 1'b1, zero = 1'b0;
  logic [31:0] zw = '0;

  mult_share_ctrl_32b #(.SETTLE_CYCLES(1)) u_s1 (
    .clk(clk), .reset(rst),
    .req0_valid(a_v), .req0_A(a_a), .req0_B(a_b), .req0_ready(a_r0),
    .req1_valid(zero), .req1_A(zw), .req1_B(zw), .req1_ready(a_r1),
    .res_valid(a_rv), .res_ready(one), .res_id(a_id), .resultado(a_res), .busy(a_busy)
  );

  mult_share_ctrl_32b #(.SETTLE_CYCLES(15)) u_s15 (
    .clk(clk), .reset(rst),
    .req0_valid(zero), .req0_A(zw), .req0_B(zw), .req0_ready(b_r0),
    .req1_valid(b_v), .req1_A(b_a), .req1_B(b_b), .req1_ready(b_r1),
    .res_valid(b_rv), .res_ready(one), .res_id(b_id), .resultado(b_res), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic bit pick(bit v0, bit v1, bit p);
    return (v0 && v1) ? p : v1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Transaction-level model: a job is in flight for S edges after acceptance,
  // then its product is shown until the consumer takes it.
  bit          m_busy = 0, m_show = 0, m_ptr = 0, m_id = 0, m_res_id = 0;
  int          m_left = 0;
  logic [63:0] m_prod = '0, m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 0; m_show <= 0; m_ptr <= 0; m_id <= 0; m_res_id <= 0;
      m_left <= 0; m_prod <= '0; m_res <= '0;
    end else if (m_show) begin
      if (resr) begin
        m_show <= 0;
        m_busy <= 0;
      end
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_res    <= m_prod;
        m_res_id <= m_id;
        m_show   <= 1;
      end
    end else if (r0v || r1v) begin
      m_id   <= pick(r0v, r1v, m_ptr);
      m_prod <= pick(r0v, r1v, m_ptr) ? 64'(r1a) * 64'(r1b) : 64'(r0a) * 64'(r0b);
      m_ptr  <= !pick(r0v, r1v, m_ptr);
      m_left <= S;
      m_busy <= 1;
    end
  end

  always @(negedge clk) begin
    bit idle;
    idle = !m_busy && !rst;
    chk("req0_ready", r0r, idle && (r0v || r1v) && !pick(r0v, r1v, m_ptr));
    chk("req1_ready", r1r, idle && (r0v || r1v) && pick(r0v, r1v, m_ptr));
    chk("ready_exclusive", r0r & r1r, 0);
    chk("res_valid", resv, m_show);
    chk("busy", busy, m_busy);
    chk("res_id", resid, m_res_id);
    chk("resultado", res, m_res);
  end

  logic [63:0] log_p[$];
  bit          log_id[$];

  always @(negedge clk) begin
    if (resv && resr) begin
      log_p.push_back(res);
      log_id.push_back(resid);
    end
  end

  task automatic send(input bit which, input logic [31:0] a, input logic [31:0] b,
                      input bit keep, output int t_acc);
    bit ok;
    @(posedge clk); #1;
    if (which) begin r1v = 1; r1a = a; r1b = b; end
    else       begin r0v = 1; r0a = a; r0b = b; end
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (which ? r1r : r0r) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout which=%0d actual=no_ready required=ready", which);
    end
    t_acc = cyc + 1;
    @(posedge clk); #1;
    if (!keep) begin
      if (which) r1v = 0; else r0v = 0;
    end
  endtask

  task automatic wait_valid(output int t);
    bit ok;
    ok = 0;
    t = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (resv) begin ok = 1; t = cyc; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL res_valid_timeout actual=0 required=1");
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, tv, n, nv;
    logic [63:0] exp_p [10];
    bit          exp_id [10];
    bit          ok;

    // Reset state
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", resv, 0);
    chk("rst_resultado", res, 0);
    @(posedge clk); #1 rst = 0;

    // Single request, latency S
    send(0, 32'd3, 32'd5, 0, t);
    wait_valid(tv);
    chk("lat_s4", 64'(tv - t), 4);
    chk("single_res", res, 64'hF);
    chk("single_id", resid, 0);
    @(negedge clk);
    chk("idle_after_done", busy, 0);

    // Max and zero operands
    send(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, t);
    wait_valid(tv);
    wait_idle();
    send(0, 32'd0, 32'hDEAD_BEEF, 0, t);
    wait_valid(tv);
    wait_idle();

    // Contention from a fresh reset
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(posedge clk); #1;
    r0v = 1; r0a = 32'd2; r0b = 32'd7;
    r1v = 1; r1a = 32'd9; r1b = 32'd9;
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (resv && resr) n++;
    end
    if (n < 4) begin
      checks++; errors++;
      $display("FAIL contention_timeout actual=%0d required=4", n);
    end
    @(posedge clk); #1;
    r0v = 0; r1v = 0;
    wait_idle();

    // Backpressure with req0 waiting
    @(posedge clk); #1 resr = 0;
    send(0, 32'd11, 32'd13, 1, t);
    r0a = 32'd4; r0b = 32'd5;
    wait_valid(tv);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_res", res, 64'd143);
      chk("bp_id", resid, 0);
      chk("bp_busy", busy, 1);
      chk("bp_ready0", r0r, 0);
    end
    @(posedge clk); #1 resr = 1;
    @(negedge clk);
    chk("bp_hs_ready0", r0r, 0);
    chk("bp_hs_valid", resv, 1);
    @(negedge clk);
    chk("bp_regrant", r0r, 1);
    @(posedge clk); #1 r0v = 0;
    wait_valid(tv);
    wait_idle();

    // Reset two cycles into BUSY
    send(0, 32'd100, 32'd100, 0, t);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1;
    r0v = 1; r0a = 32'd8; r0b = 32'd8;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_valid", resv, 0);
    chk("abort_res", res, 0);
    chk("abort_id", resid, 0);
    chk("abort_ready0", r0r, 0);
    repeat (3) @(posedge clk);
    #1 rst = 0; r0v = 0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resv) nv++;
    end
    chk("no_valid_after_reset", 64'(nv), 0);
    send(0, 32'd6, 32'd7, 0, t);
    wait_valid(tv);
    chk("post_reset_res", res, 64'd42);
    chk("post_reset_id", resid, 0);
    wait_idle();

    // Literal result table
    exp_p  = '{64'd15, 64'hFFFF_FFFE_0000_0001, 64'd0, 64'd14, 64'd81, 64'd14, 64'd81,
               64'd143, 64'd20, 64'd42};
    exp_id = '{0, 1, 0, 0, 1, 0, 1, 0, 0, 0};
    chk("log_count", 64'(log_p.size()), 10);
    for (int i = 0; i < 10 && i < log_p.size(); i++) begin
      chk($sformatf("log_p%0d", i), log_p[i], exp_p[i]);
      chk($sformatf("log_id%0d", i), 64'(log_id[i]), 64'(exp_id[i]));
    end

    // SETTLE_CYCLES = 1
    @(posedge clk); #1;
    a_v = 1; a_a = 32'd1000; a_b = 32'd1000;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_r0) begin ok = 1; break; end
    end
    chk("s1_granted", ok, 1);
    t = cyc + 1;
    @(posedge clk); #1 a_v = 0;
    ok = 0; tv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_rv) begin ok = 1; tv = cyc; break; end
    end
    chk("s1_valid_seen", ok, 1);
    chk("lat_s1", 64'(tv - t), 1);
    chk("s1_res", a_res, 64'd1000000);
    chk("s1_id", a_id, 0);

    // SETTLE_CYCLES = 15
    @(posedge clk); #1;
    b_v = 1; b_a = 32'hFFFF_FFFF; b_b = 32'd2;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b_r1) begin ok = 1; break; end
    end
    chk("s15_granted", ok, 1);
    t = cyc + 1;
    @(posedge clk); #1 b_v = 0;
    ok = 0; tv = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (b_rv) begin ok = 1; tv = cyc; break; end
    end
    chk("s15_valid_seen", ok, 1);
    chk("lat_s15", 64'(tv - t), 15);
    chk("s15_res", b_res, 64'h1_FFFF_FFFE);
    chk("s15_id", b_id, 1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl_32b.md
# mult_share_ctrl_32b

Sequencing and arbitration controller that shares one `array_multiplier_32b` instance between two requesters. It registers the winning operands and holds them stable for a fixed number of settle cycles, so the long combinational array path runs as a multicycle path. It then captures the 64-bit product and returns it with a valid/ready handshake tagged by requester ID. It sits between the lab's operand sources and the shared unsigned array multiplier, which it instantiates internally.

## Interface
- `SETTLE_CYCLES`, default 4: cycles the operands are held before the product is sampled; legal range 1..15.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operand pair.
- `req0_A`, `req0_B`  in  32 each  requester 0 operands, unsigned.
- `req0_ready`  out  1  requester 0 pair accepted this cycle.
- `req1_valid`, `req1_A`, `req1_B`, `req1_ready`: same as requester 0, for requester 1.
- `res_valid`  out  1  product available.
- `res_ready`  in  1  consumer accepts product.
- `res_id`  out  1  requester that issued the product (0 or 1).
- `resultado`  out  64  unsigned product A*B.
- `busy`  out  1  controller not in IDLE.

## Operation
FSM has three states: IDLE, BUSY, DONE.

**IDLE**
- If no `reqN_valid` is high, stay in IDLE.
- Otherwise grant one requester and assert its `reqN_ready` combinationally in the same cycle. Never assert both ready signals.
- On the clock edge, latch that requester's A/B into the operand registers, latch the ID, load the settle counter with `SETTLE_CYCLES-1`, and move to BUSY.

**Arbitration**
- Round-robin with a 1-bit priority pointer.
- If only one requester is valid, it wins.
- If both are valid, the requester named by the pointer wins.
- After each grant, the pointer moves to the other requester.
- Reset sets the pointer to requester 0.

**BUSY**
- Operand registers drive the multiplier and stay unchanged.
- The counter decrements each cycle.
- In the cycle where the counter is 0, the multiplier output is registered into `resultado` at the clock edge and the FSM moves to DONE.

**DONE**
- `res_valid` is 1; `resultado` and `res_id` are held stable.
- When `res_valid && res_ready`, move to IDLE at the clock edge.
- Without `res_ready`, stay in DONE indefinitely. No new grant is made and all `reqN_ready` stay 0.

**Arithmetic and outputs**
- Unsigned 32x32 multiply to a full 64-bit product, no truncation, no overflow possible.
- `reqN_ready` is 0 in BUSY and DONE.
- `busy` = (state != IDLE).

## Timing
**Reset values** (asynchronous; outputs take these while `reset` is high):
- State IDLE, counter 0, pointer = requester 0.
- `res_valid`=0, `res_id`=0, `resultado`=0, `busy`=0, `req0_ready`=0, `req1_ready`=0.
- `reqN_ready` is additionally gated low while `reset` is high.

**Latency**
- Accept edge is T. `res_valid` rises at edge T+`SETTLE_CYCLES`.
- `SETTLE_CYCLES`=1 gives `res_valid` one cycle after accept.
- Handshake cycle is H. Earliest next `reqN_ready` is the cycle after H.
- Best-case throughput is one product per `SETTLE_CYCLES`+2 cycles.

**Handshake rules**
- A requester must hold `valid` and operands stable until it sees `ready`.
- A requester may drop `valid` without a transfer.
- The controller samples operands only in the grant cycle.
- `resultado` is only meaningful when `res_valid`=1, and keeps its last value otherwise.

**Boundary conditions**
- Both requests present continuously: grants alternate 0,1,0,1…
- `reqN_valid` changes while in BUSY/DONE: ignored; re-evaluated only in IDLE.
- Reset asserted in BUSY or DONE: operation is aborted and the product is discarded. No `res_valid` appears after reset deasserts, and the outputs take their reset values immediately.
- `res_ready` high before DONE: no effect.

## Test plan
- **Single request:** `req0` A=3, B=5, `SETTLE_CYCLES`=4, `res_ready`=1 → `req0_ready` 1 for one cycle. `res_valid` rises 4 edges after accept with `resultado`=0x000000000000000F and `res_id`=0. FSM returns to IDLE after one DONE cycle.
- **Max operands:** `req1` A=B=0xFFFFFFFF → `resultado`=0xFFFFFFFE00000001, `res_id`=1. A=0 with B=0xDEADBEEF → `resultado`=0.
- **Contention:** both valid continuously with distinct operands (2×7 on req0, 9×9 on req1) after reset → result order is ids 0,1,0,1 with products 14,81,14,81. Ready is never high on both requesters in the same cycle.
- **Backpressure:** hold `res_ready`=0 for 10 cycles in DONE while `req0_valid`=1 → `resultado`/`res_id` stable, `busy`=1, `req0_ready`=0 throughout. Raise `res_ready` → one transfer, then `req0` is granted the following cycle.
- **Reset mid-operation:** assert `reset` two cycles into BUSY → all outputs take their reset values asynchronously. After release, no `res_valid` appears and the next request (6×7) yields 42 with `res_id`=0.
- **Parameter sweep:** `SETTLE_CYCLES`=1 and 15 → accept-to-`res_valid` is exactly 1 and 15 edges, and the products are correct.
